// File: rtl/mcycle_ctx_queue_if.sv
// rtl/mcycle_ctx_queue_if.sv - E-stage context, E/M mux output and status bundle for mcycle_ctx_queue
// Purpose: groups every non-clock signal of the multi-cycle context queue.
// master: E/D-stage side; drives E-stage context, push/pop requests and hazard query addresses.
// slave : the queue; drives the muxed *RE context, fill state, hazard and sticky error flags.
interface mcycle_ctx_queue_if #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              M_StartE;
    logic              M_DoneE;
    logic [DATA_W-1:0] InstrE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              MemtoRegE;
    logic [DATA_W-1:0] WriteDataE;
    logic [ADDR_W-1:0] RA2E;
    logic [ADDR_W-1:0] WA3E;
    logic [DATA_W-1:0] MCycleResultE;
    logic [DATA_W-1:0] ALUResultE;
    logic [ADDR_W-1:0] RA1D;
    logic [ADDR_W-1:0] RA2D;

    logic [DATA_W-1:0] InstrRE;
    logic [DATA_W-1:0] WriteDataRE;
    logic [DATA_W-1:0] OpResultRE;
    logic              RegWriteRE;
    logic              MemWriteRE;
    logic              MemtoRegRE;
    logic [ADDR_W-1:0] RA2RE;
    logic [ADDR_W-1:0] WA3RE;
    logic [CNT_W-1:0]  Count;
    logic              Full;
    logic              Empty;
    logic              PendHazardD;
    logic              Overflow;
    logic              Underflow;

    modport master (
        output M_StartE, M_DoneE, InstrE, RegWriteE, MemWriteE, MemtoRegE, WriteDataE,
               RA2E, WA3E, MCycleResultE, ALUResultE, RA1D, RA2D,
        input  InstrRE, WriteDataRE, OpResultRE, RegWriteRE, MemWriteRE, MemtoRegRE,
               RA2RE, WA3RE, Count, Full, Empty, PendHazardD, Overflow, Underflow
    );

    modport slave (
        input  M_StartE, M_DoneE, InstrE, RegWriteE, MemWriteE, MemtoRegE, WriteDataE,
               RA2E, WA3E, MCycleResultE, ALUResultE, RA1D, RA2D,
        output InstrRE, WriteDataRE, OpResultRE, RegWriteRE, MemWriteRE, MemtoRegRE,
               RA2RE, WA3RE, Count, Full, Empty, PendHazardD, Overflow, Underflow
    );
endinterface

// File: rtl/mcycle_ctx_queue.sv
// rtl/mcycle_ctx_queue.sv - FIFO of execute-stage contexts for in-flight multi-cycle ops
// Purpose: M_StartE pushes the E-stage context; M_DoneE pops the oldest context and presents
// it with MCycleResultE on the *RE outputs, otherwise *RE passes the E-stage inputs with ALUResultE.
// Ports: CLK, RESET (async, active-high); bus (slave modport) carries all context, status,
// decode-stage hazard and sticky Overflow/Underflow signals.
module mcycle_ctx_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    mcycle_ctx_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] instrMem     [DEPTH];
    logic [DATA_W-1:0] writeDataMem [DEPTH];
    logic [ADDR_W-1:0] ra2Mem       [DEPTH];
    logic [ADDR_W-1:0] wa3Mem       [DEPTH];
    logic [DEPTH-1:0]  regWriteMem;
    logic [DEPTH-1:0]  memWriteMem;
    logic [DEPTH-1:0]  memtoRegMem;
    logic [DEPTH-1:0]  validQ;

    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  countQ;
    logic              overflowQ;
    logic              underflowQ;

    logic              emptyW;
    logic              fullW;
    logic              popOk;
    logic              pushOk;
    logic              hazard;

    assign emptyW = (countQ == '0);
    assign fullW  = (countQ == CNT_W'(DEPTH));
    assign popOk  = bus.M_DoneE && !emptyW;
    // A push into a full queue is still accepted when the head leaves on the same edge.
    assign pushOk = bus.M_StartE && (!fullW || popOk);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            validQ     <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            countQ     <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            // Clear before set: on a full push+pop both pointers address the same slot,
            // and the slot must end up holding the new valid entry.
            if (popOk) begin
                validQ[rdPtr] <= 1'b0;
                rdPtr         <= rdPtr + 1'b1;
            end
            if (pushOk) begin
                validQ[wrPtr] <= 1'b1;
                wrPtr         <= wrPtr + 1'b1;
            end
            if (pushOk && !popOk) begin
                countQ <= countQ + 1'b1;
            end else if (popOk && !pushOk) begin
                countQ <= countQ - 1'b1;
            end
            if (bus.M_StartE && fullW && !popOk) begin
                overflowQ <= 1'b1;
            end
            if (bus.M_DoneE && emptyW) begin
                underflowQ <= 1'b1;
            end
        end
    end

    // Payload carries no reset; only the valid bits decide whether a slot means anything.
    always_ff @(posedge CLK) begin
        if (pushOk) begin
            instrMem[wrPtr]     <= bus.InstrE;
            writeDataMem[wrPtr] <= bus.WriteDataE;
            ra2Mem[wrPtr]       <= bus.RA2E;
            wa3Mem[wrPtr]       <= bus.WA3E;
            regWriteMem[wrPtr]  <= bus.RegWriteE;
            memWriteMem[wrPtr]  <= bus.MemWriteE;
            memtoRegMem[wrPtr]  <= bus.MemtoRegE;
        end
    end

    // The head being popped this cycle still counts: its write has not reached M yet.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (validQ[i] && regWriteMem[i] &&
                (wa3Mem[i] == bus.RA1D || wa3Mem[i] == bus.RA2D)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        bus.InstrRE     = bus.InstrE;
        bus.WriteDataRE = bus.WriteDataE;
        bus.RegWriteRE  = bus.RegWriteE;
        bus.MemWriteRE  = bus.MemWriteE;
        bus.MemtoRegRE  = bus.MemtoRegE;
        bus.RA2RE       = bus.RA2E;
        bus.WA3RE       = bus.WA3E;
        bus.OpResultRE  = bus.ALUResultE;
        if (popOk) begin
            bus.InstrRE     = instrMem[rdPtr];
            bus.WriteDataRE = writeDataMem[rdPtr];
            bus.RegWriteRE  = regWriteMem[rdPtr];
            bus.MemWriteRE  = memWriteMem[rdPtr];
            bus.MemtoRegRE  = memtoRegMem[rdPtr];
            bus.RA2RE       = ra2Mem[rdPtr];
            bus.WA3RE       = wa3Mem[rdPtr];
            bus.OpResultRE  = bus.MCycleResultE;
        end
    end

    assign bus.Count       = countQ;
    assign bus.Full        = fullW;
    assign bus.Empty       = emptyW;
    assign bus.PendHazardD = hazard;
    assign bus.Overflow    = overflowQ;
    assign bus.Underflow   = underflowQ;
endmodule

// File: tb/tb_mcycle_ctx_queue.sv
// tb/tb_mcycle_ctx_queue.sv - scoreboard bench for mcycle_ctx_queue with queue-based reference model
module tb_mcycle_ctx_queue;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] instr;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic [31:0] wd;
        logic [3:0]  ra2;
        logic [3:0]  wa3;
    } ctx_t;

    typedef struct {
        logic        done;
        ctx_t        re;
        logic [31:0] op;
        int          count;
        logic        full;
        logic        empty;
        logic        hz;
        logic        ov;
        logic        un;
    } exp_t;

    logic CLK;
    logic RESET;
    int   tests;
    int   fails;

    ctx_t mq[$];
    exp_t expQ[$];
    logic ovM;
    logic unM;

    mcycle_ctx_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) bus ();

    mcycle_ctx_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ctx_t mk(input logic [31:0] instr, input logic rw, input logic [3:0] wa3);
        ctx_t c;
        c.instr = instr;
        c.rw    = rw;
        c.mw    = 1'($urandom);
        c.m2r   = 1'($urandom);
        c.wd    = $urandom;
        c.ra2   = 4'($urandom);
        c.wa3   = wa3;
        return c;
    endfunction

    function automatic ctx_t rnd();
        return mk($urandom, 1'($urandom), 4'($urandom_range(0, 7)));
    endfunction

    // Drives one cycle just after a rising edge; the model predicts what the DUT shows
    // during this cycle, then advances by the queue rules to the next edge.
    task automatic doCycle(input logic st, input logic dn, input ctx_t c,
                           input logic [31:0] mres, input logic [31:0] alu,
                           input logic [3:0] ra1, input logic [3:0] ra2d);
        exp_t x;
        logic popOk;
        bus.M_StartE      = st;
        bus.M_DoneE       = dn;
        bus.InstrE        = c.instr;
        bus.RegWriteE     = c.rw;
        bus.MemWriteE     = c.mw;
        bus.MemtoRegE     = c.m2r;
        bus.WriteDataE    = c.wd;
        bus.RA2E          = c.ra2;
        bus.WA3E          = c.wa3;
        bus.MCycleResultE = mres;
        bus.ALUResultE    = alu;
        bus.RA1D          = ra1;
        bus.RA2D          = ra2d;

        x.done  = dn;
        x.count = mq.size();
        x.full  = (mq.size() == DEPTH);
        x.empty = (mq.size() == 0);
        x.ov    = ovM;
        x.un    = unM;
        x.hz    = 1'b0;
        foreach (mq[i]) if (mq[i].rw && (mq[i].wa3 == ra1 || mq[i].wa3 == ra2d)) x.hz = 1'b1;
        popOk = dn && (mq.size() > 0);
        x.re  = popOk ? mq[0] : c;
        x.op  = popOk ? mres : alu;
        expQ.push_back(x);

        if (dn && mq.size() == 0) unM = 1'b1;
        if (st && mq.size() == DEPTH && !popOk) ovM = 1'b1;
        if (popOk) void'(mq.pop_front());
        if (st && mq.size() < DEPTH) mq.push_back(c);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        doCycle(1'b0, 1'b0, rnd(), $urandom, $urandom, 4'hF, 4'hF);
    endtask

    // Monitor: status is observed every cycle; the muxed context is the DUT's output
    // whenever M_DoneE is presented, and is checked against the scoreboard entry.
    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk("Count", 32'(bus.Count), 32'(e.count));
            chk("Full", 32'(bus.Full), 32'(e.full));
            chk("Empty", 32'(bus.Empty), 32'(e.empty));
            chk("PendHazardD", 32'(bus.PendHazardD), 32'(e.hz));
            chk("Overflow", 32'(bus.Overflow), 32'(e.ov));
            chk("Underflow", 32'(bus.Underflow), 32'(e.un));
            if (bus.M_DoneE) begin
                chk("InstrRE", bus.InstrRE, e.re.instr);
                chk("RegWriteRE", 32'(bus.RegWriteRE), 32'(e.re.rw));
                chk("MemWriteRE", 32'(bus.MemWriteRE), 32'(e.re.mw));
                chk("MemtoRegRE", 32'(bus.MemtoRegRE), 32'(e.re.m2r));
                chk("WriteDataRE", bus.WriteDataRE, e.re.wd);
                chk("RA2RE", 32'(bus.RA2RE), 32'(e.re.ra2));
                chk("WA3RE", 32'(bus.WA3RE), 32'(e.re.wa3));
                chk("OpResultRE", bus.OpResultRE, e.op);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        ovM   = 1'b0;
        unM   = 1'b0;
        RESET = 1'b1;
        bus.M_StartE = 1'b0;
        bus.M_DoneE  = 1'b0;
        bus.InstrE = '0; bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b0; bus.MemtoRegE = 1'b0;
        bus.WriteDataE = '0; bus.RA2E = '0; bus.WA3E = '0;
        bus.MCycleResultE = '0; bus.ALUResultE = '0; bus.RA1D = '0; bus.RA2D = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_Count", 32'(bus.Count), 0);
        chk("rst_Empty", 32'(bus.Empty), 1);
        chk("rst_Full", 32'(bus.Full), 0);
        chk("rst_Overflow", 32'(bus.Overflow), 0);
        chk("rst_Underflow", 32'(bus.Underflow), 0);
        chk("rst_PendHazardD", 32'(bus.PendHazardD), 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Single op
        doCycle(1'b1, 1'b0, mk(32'hE0010392, 1'b1, 4'd3), 0, $urandom, 4'hF, 4'hF);
        repeat (3) idle();
        doCycle(1'b0, 1'b1, rnd(), 32'h0000002A, $urandom, 4'hF, 4'hF);
        idle();

        // Ordering and pointer wrap
        doCycle(1'b1, 1'b0, mk($urandom, 1'b1, 4'd1), 0, 0, 4'hF, 4'hF);
        doCycle(1'b1, 1'b0, mk($urandom, 1'b1, 4'd2), 0, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b1, rnd(), 32'h11, 0, 4'hF, 4'hF);
        doCycle(1'b1, 1'b0, mk($urandom, 1'b1, 4'd5), 0, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b1, rnd(), 32'h22, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b1, rnd(), 32'h33, 0, 4'hF, 4'hF);
        idle();

        // Overflow, then simultaneous push+pop while full
        doCycle(1'b1, 1'b0, rnd(), 0, 0, 4'hF, 4'hF);
        doCycle(1'b1, 1'b0, rnd(), 0, 0, 4'hF, 4'hF);
        doCycle(1'b1, 1'b0, rnd(), 0, 0, 4'hF, 4'hF);
        doCycle(1'b1, 1'b1, rnd(), $urandom, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b1, rnd(), $urandom, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b1, rnd(), $urandom, 0, 4'hF, 4'hF);
        idle();

        // Hazard and underflow
        doCycle(1'b1, 1'b0, mk($urandom, 1'b1, 4'd7), 0, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b0, rnd(), 0, 0, 4'h0, 4'd7);
        doCycle(1'b0, 1'b1, rnd(), $urandom, 0, 4'd7, 4'h0);
        doCycle(1'b1, 1'b0, mk($urandom, 1'b0, 4'd7), 0, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b0, rnd(), 0, 0, 4'h0, 4'd7);
        doCycle(1'b0, 1'b1, rnd(), $urandom, 0, 4'hF, 4'hF);
        doCycle(1'b0, 1'b1, rnd(), $urandom, $urandom, 4'hF, 4'hF);
        doCycle(1'b1, 1'b1, rnd(), $urandom, $urandom, 4'hF, 4'hF);
        doCycle(1'b0, 1'b1, rnd(), $urandom, $urandom, 4'hF, 4'hF);

        // Asynchronous reset with two pending entries, between clock edges
        doCycle(1'b1, 1'b0, mk($urandom, 1'b1, 4'd4), 0, 0, 4'hF, 4'hF);
        doCycle(1'b1, 1'b0, mk($urandom, 1'b1, 4'd6), 0, 0, 4'hF, 4'hF);
        bus.M_StartE = 1'b0;
        bus.M_DoneE  = 1'b0;
        bus.RA1D     = 4'd4;
        bus.RA2D     = 4'd6;
        #1;
        chk("pre_async_Count", 32'(bus.Count), 2);
        chk("pre_async_PendHazardD", 32'(bus.PendHazardD), 1);
        #1;
        RESET = 1'b1;
        #1;
        chk("async_Count", 32'(bus.Count), 0);
        chk("async_Empty", 32'(bus.Empty), 1);
        chk("async_Full", 32'(bus.Full), 0);
        chk("async_Overflow", 32'(bus.Overflow), 0);
        chk("async_Underflow", 32'(bus.Underflow), 0);
        chk("async_PendHazardD", 32'(bus.PendHazardD), 0);
        mq.delete();
        ovM = 1'b0;
        unM = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            doCycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), rnd(),
                    $urandom, $urandom, 4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)));
        end

        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 32'(expQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
